lcd12864_ctrl: RTL and testbench
================================

# lcd12864_ctrl

Command/data sequencer for the 128x64 ST7920 panel's serial byte transmitter. After reset it waits out panel power-up, issues the fixed init command list, then on each refresh request streams a 4-row x 16-char text frame. Characters come from an external synchronous character RAM, and the DDRAM address commands are generated internally. Sits between the user/text logic and the serial transmitter, which owns CS/SCLK/SID framing (sync byte, nibble split); this block only decides which byte to send, whether it is a command or data (RS), and when.

## Interface
- T_PWR, 2_000_000: clk cycles of power-up wait after reset release (40 ms @ 50 MHz)
- T_CMD, 3_600: idle clk cycles after each byte's tx_done (72 us); must be >= 2
- T_CLR, 80_000: idle clk cycles after the clear command instead of T_CMD (1.6 ms)
- CW, 21: wait counter width; must hold max(T_PWR, T_CLR, T_CMD)
- clk  in  1  system clock
- nCR  in  1  reset, asynchronous, active-low
- refresh  in  1  one-cycle pulse requesting a full frame write
- tx_start  out  1  one-cycle pulse: transmitter begins frame for tx_rs/tx_data
- tx_rs  out  1  0 = command, 1 = display data
- tx_data  out  8  byte to send; held stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse from transmitter: byte frame finished
- ch_addr  out  6  char RAM read address {row[1:0], col[3:0]}
- ch_data  in  8  char RAM read data, valid 1 cycle after ch_addr
- busy  out  1  high while initialising or refreshing
- init_done  out  1  sticky high once the init list is complete

## Operation
- States: PWR_WAIT, INIT_SEND, INIT_ACK, INIT_GAP, IDLE, FR_SEND, FR_ACK, FR_GAP.
- Init list, all tx_rs=0, in order: 0x30, 0x30, 0x0C, 0x01, 0x06. Gap after 0x01 is T_CLR; after the others it is T_CMD.
- Frame: for row r = 0..3, send the command address byte (0x80, 0x90, 0x88, 0x98 for r=0..3, tx_rs=0). Then send 16 data bytes (tx_rs=1) taken from ch_data at ch_addr={r, c}, c=0..15. Every byte is followed by a T_CMD gap. Total: 68 transfers per frame.
- *_SEND: assert tx_start for exactly one cycle with tx_rs/tx_data valid, then enter *_ACK.
- *_ACK: hold outputs and wait for tx_done. There is no timeout.
- *_GAP: load the counter, count down, then go to the next SEND (or to IDLE after the last byte).
- ch_addr is a register that points at the next char. It updates at the tx_done of the previous byte, so RAM data is settled before the next tx_start. The data byte is captured into tx_data on the tx_start cycle.
- refresh in IDLE (with init_done=1) starts a frame.
- A refresh while busy (init or frame) sets a single pending flag. Extra refreshes merge into that flag. When the current sequence ends, the pending frame starts instead of entering IDLE, and the flag clears.
- tx_done outside an *_ACK state is ignored.
- init_done rises at the end of the gap after 0x06 and stays high until reset.

## Timing
- Reset values: state=PWR_WAIT, tx_start=0, tx_rs=0, tx_data=0x00, ch_addr=0, busy=1, init_done=0, pending=0, counter=T_PWR.
- First tx_start (0x30) is asserted on the (T_PWR+1)th rising edge after nCR deasserts.
- Gap rule: between the cycle in which tx_done is sampled high and the next tx_start cycle there are exactly T_CMD idle cycles, or T_CLR after 0x01.
- busy falls in the same cycle the state enters IDLE.
- A refresh arriving in the same cycle busy falls is treated as pending: the frame starts immediately, and busy does not drop.
- Reset mid-operation: all registers return to reset values immediately, and the full init sequence reruns.

## Test plan
Bench settings: T_PWR=20, T_CMD=4, T_CLR=10. The transmitter model pulses tx_done 3 cycles after tx_start. The RAM model returns ch_data=0x40+addr.

- Release reset, no refresh -> tx_start cycles carry 0x30, 0x30, 0x0C, 0x01, 0x06, all rs=0; first tx_start at edge 21. init_done and busy-low occur 10 idle cycles after 0x01's done and 4 after 0x06's done.
- One refresh after init -> 68 transfers in order 0x80, 0x40..0x4F, 0x90, 0x50..0x5F, 0x88, 0x60..0x6F, 0x98, 0x70..0x7F. Address bytes have rs=0 and char bytes rs=1. busy returns to 0 after the final gap.
- Three refresh pulses during the first frame -> exactly one additional frame (136 transfers total), then IDLE.
- refresh pulsed during init -> a frame starts directly after the 0x06 gap, and busy stays high throughout.
- Transmitter delays tx_done by 50 cycles; a spurious tx_done is injected during a gap -> tx_data stays stable for the whole wait, the spurious pulse is ignored, and the sequence stays intact.
- nCR pulsed low mid-frame (after 0x88) -> outputs return to reset values asynchronously, and the init list restarts from 0x30 after T_PWR.

Source files
------------

// File: rtl/lcd12864_ctrl.sv
// ST7920 byte sequencer: power-up wait, fixed init command list, then 4x16 text
// frames whose characters are read from an external synchronous char RAM.
module lcd12864_ctrl #(
   parameter int T_PWR = 2_000_000,
   parameter int T_CMD = 3_600,
   parameter int T_CLR = 80_000,
   parameter int CW    = 21
) (
   input  logic       clk,
   input  logic       nCR,
   input  logic       refresh,
   output logic       tx_start,
   output logic       tx_rs,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic [5:0] ch_addr,
   input  logic [7:0] ch_data,
   output logic       busy,
   output logic       init_done,
   output logic [2:0] dbg_state
);

   // Transmitter handshake: tx_start is a one-cycle pulse with tx_rs/tx_data valid;
   // both stay frozen until the one-cycle tx_done, which is honoured only in *_ACK.
   typedef enum logic [2:0] {
      PWR_WAIT, INIT_SEND, INIT_ACK, INIT_GAP, IDLE, FR_SEND, FR_ACK, FR_GAP
   } state_t;

   localparam logic [CW-1:0] PWR_LD = CW'(T_PWR);
   localparam logic [CW-1:0] CMD_LD = CW'(T_CMD - 1);
   localparam logic [CW-1:0] CLR_LD = CW'(T_CLR - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    init_idx;
   logic          pending;
   logic          fr_cmd;
   logic          fr_last;
   logic [7:0]    init_byte;
   logic [7:0]    row_cmd;
   logic          seq_end;
   logic          frame_go;

   assign dbg_state = state;

   always_comb begin
      init_byte = 8'h06;
      case (init_idx)
         3'd0, 3'd1: init_byte = 8'h30;
         3'd2:       init_byte = 8'h0C;
         3'd3:       init_byte = 8'h01;
         default:    init_byte = 8'h06;
      endcase
   end

   // DDRAM row start addresses of the ST7920 are interleaved.
   always_comb begin
      row_cmd = 8'h80;
      case (ch_addr[5:4])
         2'd0: row_cmd = 8'h80;
         2'd1: row_cmd = 8'h90;
         2'd2: row_cmd = 8'h88;
         2'd3: row_cmd = 8'h98;
         default: row_cmd = 8'h80;
      endcase
   end

   always_comb begin
      seq_end  = (cnt == '0) &&
                 (((state == INIT_GAP) && (init_idx == 3'd5)) ||
                  ((state == FR_GAP) && fr_last));
      // A refresh landing on the very cycle a sequence ends counts as pending.
      frame_go = (seq_end && (pending || refresh)) ||
                 ((state == IDLE) && refresh && init_done);
   end

   always_ff @(posedge clk or negedge nCR) begin
      if (!nCR) begin
         state     <= PWR_WAIT;
         cnt       <= PWR_LD;
         init_idx  <= 3'd0;
         pending   <= 1'b0;
         fr_cmd    <= 1'b1;
         fr_last   <= 1'b0;
         tx_start  <= 1'b0;
         tx_rs     <= 1'b0;
         tx_data   <= 8'h00;
         ch_addr   <= 6'd0;
         busy      <= 1'b1;
         init_done <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (refresh && (state != IDLE)) pending <= 1'b1;

         case (state)
            PWR_WAIT: begin
               if (cnt == '0) begin
                  state    <= INIT_SEND;
                  tx_start <= 1'b1;
                  tx_rs    <= 1'b0;
                  tx_data  <= init_byte;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            INIT_SEND: state <= INIT_ACK;
            INIT_ACK: begin
               if (tx_done) begin
                  state    <= INIT_GAP;
                  cnt      <= (init_idx == 3'd3) ? CLR_LD : CMD_LD;
                  init_idx <= init_idx + 3'd1;
               end
            end
            INIT_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (init_idx == 3'd5) begin
                  init_done <= 1'b1;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  state    <= INIT_SEND;
                  tx_start <= 1'b1;
                  tx_rs    <= 1'b0;
                  tx_data  <= init_byte;
               end
            end
            IDLE: ;
            FR_SEND: state <= FR_ACK;
            FR_ACK: begin
               if (tx_done) begin
                  state <= FR_GAP;
                  cnt   <= CMD_LD;
                  // Advancing here gives the RAM the whole gap to settle.
                  if (tx_rs) begin
                     ch_addr <= ch_addr + 6'd1;
                     if (&ch_addr[3:0]) fr_cmd <= 1'b1;
                     fr_last <= &ch_addr;
                  end
               end
            end
            FR_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (fr_last) begin
                  fr_last <= 1'b0;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  state    <= FR_SEND;
                  tx_start <= 1'b1;
                  if (fr_cmd) begin
                     tx_rs   <= 1'b0;
                     tx_data <= row_cmd;
                     fr_cmd  <= 1'b0;
                  end else begin
                     tx_rs   <= 1'b1;
                     tx_data <= ch_data;
                  end
               end
            end
            default: state <= PWR_WAIT;
         endcase

         if (frame_go) begin
            state    <= FR_SEND;
            tx_start <= 1'b1;
            tx_rs    <= 1'b0;
            tx_data  <= row_cmd;
            fr_cmd   <= 1'b0;
            busy     <= 1'b1;
            pending  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd12864_ctrl.sv
// Bench for lcd12864_ctrl: transmitter and char RAM models, byte/gap scoreboard,
// and one task per scenario.
module tb_lcd12864_ctrl;

   localparam int T_PWR = 20;
   localparam int T_CMD = 4;
   localparam int T_CLR = 10;

   logic       clk = 1'b0;
   logic       nCR = 1'b0;
   logic       refresh = 1'b0;
   logic       tx_start;
   logic       tx_rs;
   logic [7:0] tx_data;
   logic       tx_done;
   logic [5:0] ch_addr;
   logic [7:0] ch_data;
   logic       busy;
   logic       init_done;
   logic [2:0] dbg_state;

   logic xmit_done = 1'b0;
   logic spur_done = 1'b0;
   assign tx_done = xmit_done | spur_done;

   lcd12864_ctrl #(.T_PWR(T_PWR), .T_CMD(T_CMD), .T_CLR(T_CLR), .CW(21)) dut (
      .clk(clk), .nCR(nCR), .refresh(refresh),
      .tx_start(tx_start), .tx_rs(tx_rs), .tx_data(tx_data), .tx_done(tx_done),
      .ch_addr(ch_addr), .ch_data(ch_data),
      .busy(busy), .init_done(init_done), .dbg_state(dbg_state)
   );

   // clock / reset-relative edge counter
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or negedge nCR)
      if (!nCR) cyc <= 0;
      else      cyc <= cyc + 1;

   always @(posedge clk) ch_data <= 8'h40 + {2'b00, ch_addr};

   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] exp_q[$];
   int         exp_next_edge = 0;
   bit         gap_valid = 0;
   int         last_done_edge = 0;
   int         n_tx = 0;
   int         n_done = 0;
   int         tx_delay = 3;
   bit         spur_en = 0;
   logic [7:0] row_tab [4] = '{8'h80, 8'h90, 8'h88, 8'h98};

   // scoreboard monitor: byte content and gap timing at every tx_start
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (nCR && tx_start) begin
            n_tx++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL tx_unexpected: got rs=%0b data=%02h, none expected", tx_rs, tx_data);
            end else begin
               e = exp_q.pop_front();
               if ({tx_rs, tx_data} !== e) begin
                  miscompares++;
                  $display("FAIL tx_byte: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                           tx_rs, tx_data, e[8], e[7:0]);
               end
            end
            if (gap_valid) begin
               vectors++;
               gap_valid = 0;
               if (cyc !== exp_next_edge) begin
                  miscompares++;
                  $display("FAIL tx_start_edge: got edge %0d, expected edge %0d", cyc, exp_next_edge);
               end
            end
         end
      end
   end

   // transmitter model: tx_done tx_delay cycles after tx_start, checks hold stability
   initial begin
      logic [7:0] s_data;
      logic       s_rs;
      bit         stable;
      forever begin
         @(negedge clk);
         if (nCR && tx_start) begin
            s_data = tx_data;
            s_rs   = tx_rs;
            stable = 1;
            repeat (tx_delay - 1) begin
               @(negedge clk);
               if (tx_data !== s_data || tx_rs !== s_rs) stable = 0;
            end
            vectors++;
            if (!stable) begin
               miscompares++;
               $display("FAIL tx_hold: got data=%02h rs=%0b at done, held value data=%02h rs=%0b",
                        tx_data, tx_rs, s_data, s_rs);
            end
            xmit_done = 1'b1;
            last_done_edge = cyc + 1;
            exp_next_edge = last_done_edge + ((s_rs == 1'b0 && s_data == 8'h01) ? T_CLR : T_CMD);
            gap_valid = 1;
            n_done++;
            @(negedge clk);
            xmit_done = 1'b0;
            if (spur_en) begin
               spur_done = 1'b1;
               @(negedge clk);
               spur_done = 1'b0;
            end
         end
      end
   end

   // driver tasks
   task automatic push_init();
      exp_q.push_back({1'b0, 8'h30});
      exp_q.push_back({1'b0, 8'h30});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
   endtask

   task automatic push_frame();
      for (int r = 0; r < 4; r++) begin
         exp_q.push_back({1'b0, row_tab[r]});
         for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, 8'(8'h40 + r * 16 + c)});
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      nCR = 1'b1;
      exp_next_edge = T_PWR + 1;
      gap_valid = 1;
   endtask

   task automatic pulse_refresh();
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic wait_busy_low(input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   // scenario tasks
   task automatic test_reset();
      nCR = 1'b0;
      refresh = 1'b0;
      #12;
      vectors++;
      if ({tx_start, tx_rs, tx_data, ch_addr, busy, init_done, dbg_state} !==
          {1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got start=%0b rs=%0b data=%02h addr=%0d busy=%0b init_done=%0b state=%0d",
                  tx_start, tx_rs, tx_data, ch_addr, busy, init_done, dbg_state);
      end
      push_init();
      release_reset();
   endtask

   task automatic test_init();
      bit early = 0;
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
         if (init_done) early = 1;
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL init_timeout: busy=%0b after 400 cycles, expected 0", busy);
      end
      vectors++;
      if (early) begin
         miscompares++;
         $display("FAIL init_done_early: got 1 while busy, expected 0");
      end
      vectors++;
      if (cyc !== last_done_edge + T_CMD) begin
         miscompares++;
         $display("FAIL init_busy_fall: got edge %0d, expected %0d", cyc, last_done_edge + T_CMD);
      end
      vectors++;
      if (init_done !== 1'b1) begin
         miscompares++;
         $display("FAIL init_done: got %0b, expected 1", init_done);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL init_left: got %0d pending bytes, expected 0", exp_q.size());
      end
   endtask

   task automatic test_frame();
      int n0;
      bit ok;
      gap_valid = 0;
      n0 = n_tx;
      push_frame();
      pulse_refresh();
      vectors++;
      if ({busy, tx_start} !== 2'b11) begin
         miscompares++;
         $display("FAIL frame_start: got busy=%0b start=%0b, expected 1 1", busy, tx_start);
      end
      wait_busy_low(1500, ok);
      vectors++;
      if (!ok || (n_tx - n0) != 68) begin
         miscompares++;
         $display("FAIL frame_count: got %0d transfers (idle=%0b), expected 68", n_tx - n0, ok);
      end
      vectors++;
      if (exp_q.size() != 0 || ch_addr !== 6'd0) begin
         miscompares++;
         $display("FAIL frame_end: got %0d left, addr=%0d, expected 0 left, addr=0", exp_q.size(), ch_addr);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      int n1;
      bit ok;
      gap_valid = 0;
      n0 = n_tx;
      push_frame();
      push_frame();
      pulse_refresh();
      repeat (40) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         pulse_refresh();
         repeat ($urandom_range(10, 40)) @(negedge clk);
      end
      wait_busy_low(2500, ok);
      vectors++;
      if (!ok || (n_tx - n0) != 136) begin
         miscompares++;
         $display("FAIL merge_count: got %0d transfers (idle=%0b), expected 136", n_tx - n0, ok);
      end
      n1 = n_tx;
      repeat (60) @(negedge clk);
      vectors++;
      if (n_tx != n1 || busy !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL merge_idle: got %0d extra transfers busy=%0b left=%0d, expected 0 0 0",
                  n_tx - n1, busy, exp_q.size());
      end
   endtask

   task automatic test_refresh_during_init();
      int n0;
      bit ok;
      @(negedge clk);
      nCR = 1'b0;
      exp_q.delete();
      gap_valid = 0;
      push_init();
      push_frame();
      repeat (2) @(negedge clk);
      n0 = n_tx;
      release_reset();
      repeat (30) @(negedge clk);
      pulse_refresh();
      wait_busy_low(1500, ok);
      vectors++;
      if (!ok || (n_tx - n0) != 73) begin
         miscompares++;
         $display("FAIL init_pending: got %0d transfers before busy fell (idle=%0b), expected 73", n_tx - n0, ok);
      end
      vectors++;
      if (exp_q.size() != 0 || init_done !== 1'b1) begin
         miscompares++;
         $display("FAIL init_pending_end: got left=%0d init_done=%0b, expected 0 1", exp_q.size(), init_done);
      end
   endtask

   task automatic test_slow_tx();
      int n0;
      bit ok;
      tx_delay = 50;
      spur_en = 1;
      gap_valid = 0;
      n0 = n_tx;
      push_frame();
      pulse_refresh();
      wait_busy_low(6000, ok);
      vectors++;
      if (!ok || (n_tx - n0) != 68 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL slow_frame: got %0d transfers left=%0d idle=%0b, expected 68 0 1",
                  n_tx - n0, exp_q.size(), ok);
      end
      tx_delay = 3;
      spur_en = 0;
   endtask

   task automatic test_reset_mid_frame();
      int n0;
      int d0;
      bit ok;
      gap_valid = 0;
      n0 = n_tx;
      push_frame();
      pulse_refresh();
      for (int i = 0; i < 600 && (n_tx - n0) < 35; i++) @(negedge clk);
      d0 = n_done;
      for (int i = 0; i < 20 && n_done == d0; i++) @(negedge clk);
      vectors++;
      if ((n_tx - n0) != 35 || n_done == d0 || ch_addr !== 6'd32) begin
         miscompares++;
         $display("FAIL midframe_reach: got %0d transfers addr=%0d, expected 35 after 0x88 done, addr=32",
                  n_tx - n0, ch_addr);
      end
      @(negedge clk);
      #2 nCR = 1'b0;
      #1;
      vectors++;
      if ({tx_start, tx_rs, tx_data, ch_addr, busy, init_done, dbg_state} !==
          {1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL async_reset: got start=%0b rs=%0b data=%02h addr=%0d busy=%0b init_done=%0b state=%0d",
                  tx_start, tx_rs, tx_data, ch_addr, busy, init_done, dbg_state);
      end
      exp_q.delete();
      gap_valid = 0;
      push_init();
      repeat (3) @(negedge clk);
      n0 = n_tx;
      release_reset();
      wait_busy_low(400, ok);
      vectors++;
      if (!ok || (n_tx - n0) != 5 || exp_q.size() != 0 || init_done !== 1'b1) begin
         miscompares++;
         $display("FAIL reinit: got %0d transfers left=%0d init_done=%0b idle=%0b, expected 5 0 1 1",
                  n_tx - n0, exp_q.size(), init_done, ok);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init();
      test_frame();
      test_back_to_back();
      test_refresh_during_init();
      test_slow_tx();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
